// File: rtl/vga_timing.sv
// VGA timing generator: pixel-rate tick from the system clock, horizontal and
// vertical counters, active-low syncs and blanked colour, all registered on the
// pixel tick so sync and colour leave the block aligned with each other.
module vga_timing #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_r,
  input  logic       pix_g,
  input  logic       pix_b,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       pix_en,
  output logic       active,
  output logic       frame_start,
  output logic       Hsync,
  output logic       Vsync,
  output logic [2:0] vgaRed,
  output logic [2:0] vgaGreen,
  output logic [1:0] vgaBlue
);

  // H_TOTAL and V_TOTAL must stay <= 1024; every count compare is 10 bits wide.
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Everything that goes to the connector, updated together on the tick.
  typedef struct packed {
    logic       hs_n;
    logic       vs_n;
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
  } vga_out_t;

  localparam vga_out_t OUT_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, red: 3'd0,
                                    green: 3'd0, blue: 2'd0};

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_q;
  logic [9:0]       v_q;
  logic             tick;
  logic             h_wrap;
  logic             v_wrap;
  logic             in_hsync;
  logic             in_vsync;
  vga_out_t         out_d;
  vga_out_t         out_q;

  // Tick decode; gated by reset so a CLK_DIV of 1 still shows no tick in reset.
  assign tick   = (div_cnt == DIV_LAST);
  assign pix_en = rst_n & tick;

  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);

  // Counts are visible for the whole pixel period straight from the registers.
  assign hcount      = h_q;
  assign vcount      = v_q;
  assign active      = (h_q < H_ACT) && (v_q < V_ACT);
  assign frame_start = pix_en & h_wrap & v_wrap;

  assign in_hsync = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
  assign in_vsync = (v_q >= VS_FIRST) && (v_q <= VS_LAST);

  // System-clock divider: 0..CLK_DIV-1, tick on the last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Column counter: advances once per tick, wraps at the end of the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      h_q <= '0;
    else if (pix_en) h_q <= h_wrap ? 10'd0 : h_q + 10'd1;
  end

  // Line counter: advances only on the tick that wraps the column counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                v_q <= '0;
    else if (pix_en && h_wrap) v_q <= v_wrap ? 10'd0 : v_q + 10'd1;
  end

  // Next connector values for the pixel currently addressed by h_q/v_q.
  always_comb begin
    out_d       = OUT_IDLE;
    out_d.hs_n  = ~in_hsync;
    out_d.vs_n  = ~in_vsync;
    if (active) begin
      out_d.red   = {3{pix_r}};
      out_d.green = {3{pix_g}};
      out_d.blue  = {2{pix_b}};
    end
  end

  // Connector register: one pixel period behind the counts, held between ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      out_q <= OUT_IDLE;
    else if (pix_en) out_q <= out_d;
  end

  assign Hsync    = out_q.hs_n;
  assign Vsync    = out_q.vs_n;
  assign vgaRed   = out_q.red;
  assign vgaGreen = out_q.green;
  assign vgaBlue  = out_q.blue;

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning system clocks per pixel (100 MHz -> 25 MHz pixel rate).
REQ-002 SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, meaning horizontal timing in pixels; H_TOTAL = sum = 800.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, meaning vertical timing in lines; V_TOTAL = sum = 525.
REQ-004 SHALL have port clk, input, 1, the single system clock; all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports pix_r, pix_g, pix_b, input, 1 each, pixel colour from game logic for the current hcount/vcount.
REQ-007 SHALL have ports hcount and vcount, output, 10 each, current pixel column and line.
REQ-008 SHALL have port pix_en, output, 1, one-clk pixel tick.
REQ-009 SHALL have port active, output, 1, high while hcount < H_ACTIVE and vcount < V_ACTIVE.
REQ-010 SHALL have port frame_start, output, 1, one-clk pulse at frame wrap.
REQ-011 SHALL have ports Hsync and Vsync, output, 1 each, active-low sync to the connector.
REQ-012 SHALL have ports vgaRed (3), vgaGreen (3), vgaBlue (2), output, registered colour to the connector.

Function
REQ-013 SHALL count div_cnt 0..CLK_DIV-1 and wrap to 0; pix_en SHALL be high for exactly the clk where div_cnt = CLK_DIV-1.
REQ-014 SHALL hold hcount/vcount stable between ticks; on pix_en, hcount SHALL increment; at H_TOTAL-1 it SHALL wrap to 0.
REQ-015 SHALL increment vcount only on the tick where hcount wraps; at V_TOTAL-1 it SHALL wrap to 0.
REQ-016 SHALL drive hcount, vcount and active combinationally from the counter registers, valid for the whole pixel period.
REQ-017 SHALL assert frame_start on the clk where pix_en is high and (hcount, vcount) = (H_TOTAL-1, V_TOTAL-1); never otherwise.
REQ-018 SHALL, on each pix_en, register Hsync = 0 iff hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751 default), else 1.
REQ-019 SHALL, on each pix_en, register Vsync = 0 iff vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491 default), else 1.
REQ-020 SHALL, on each pix_en, register vgaRed = {3{pix_r}}, vgaGreen = {3{pix_g}}, vgaBlue = {2{pix_b}} when active, else all zero (blanking).
REQ-021 SHALL give colour and sync outputs a latency of exactly one pixel period relative to their counts, so they stay mutually aligned.
REQ-022 SHALL ignore pix_r/g/b on clks without pix_en; registered outputs SHALL hold between ticks.
REQ-023 SHALL perform all counter comparisons at 10-bit width; parameters SHALL keep H_TOTAL, V_TOTAL <= 1024.

Reset
REQ-024 SHALL, while rst_n = 0, force div_cnt = 0, hcount = 0, vcount = 0, pix_en = 0, frame_start = 0, Hsync = 1, Vsync = 1, and all colour outputs = 0, independent of clk.
REQ-025 SHALL, after rst_n rises, produce the first pix_en on the CLK_DIV-th rising edge; reset asserted mid-frame SHALL restart at (0,0) with no partial sync pulse.

Verification
REQ-026 Release reset, run 4 clks -> pix_en high only on clk 4; hcount steps 0->1 after that tick.
REQ-027 Run one line (3200 clks) -> hcount wraps 799->0, vcount 0->1; Hsync low for exactly 96 ticks, first low output on the tick after hcount = 656.
REQ-028 Run one frame (1,680,000 clks) -> exactly one frame_start; Vsync low for exactly 1600 ticks, covering lines 490-491 delayed by one pixel.
REQ-029 Hold pix_r = 1, pix_g = 0, pix_b = 1 -> vgaRed = 7, vgaGreen = 0, vgaBlue = 3 inside active; all zero at hcount >= 641 and vcount >= 481 (one-pixel delay).
REQ-030 Assert rst_n = 0 asynchronously at (hcount 700, vcount 491) -> Hsync = Vsync = 1 and counts = 0 immediately, before the next clk edge.
REQ-031 Toggle pix_r on non-tick clks only -> vgaRed never changes.
